// File: rtl/fact_pkg.sv
// Shared types and default widths for the time-shared factorial scheduler.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_NW   = 4;
  localparam int unsigned DEF_RW   = 32;
  localparam int unsigned DEF_IDW  = 2;

  // Largest n whose factorial still fits in 32 bits.
  localparam int unsigned MAX_NOOVF_N = 12;

endpackage

// File: rtl/fact_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            vld_o
);

  always_comb begin : search
    logic        found;
    int unsigned pos;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = (32'(ptr_i) + off) % NREQ;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDW'(pos);
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one iterative factorial engine among NREQ requesters.
module fact_sched
  import fact_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned NW   = DEF_NW,
  parameter int unsigned RW   = DEF_RW,
  parameter int unsigned IDW  = DEF_IDW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NW-1:0]   opa,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [RW-1:0]        result,
  output logic                 ovf
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NW-1:0]   n_q, n_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [NW:0]     cnt_q, cnt_d;
  logic            ovfr_q, ovfr_d;

  logic            busy_q, done_q, ovf_q;
  logic [IDW-1:0]  did_q;
  logic [RW-1:0]   res_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_vld;
  logic            accept;
  logic [NW-1:0]   win_opa;
  logic [2*RW-1:0] prod;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Reset gates the accept so no grant is visible while reset is held.
  assign accept  = (state_q == IDLE) && arb_vld && reset;
  assign gnt     = accept ? arb_gnt : '0;
  assign win_opa = opa[arb_idx*NW +: NW];
  assign prod    = {{RW{1'b0}}, acc_q} * {{(2*RW-NW-1){1'b0}}, cnt_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    n_d     = n_q;
    id_d    = id_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovfr_d  = ovfr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          n_d     = win_opa;
          id_d    = arb_idx;
          acc_d   = RW'(1);
          cnt_d   = (NW+1)'(2);
          ovfr_d  = 1'b0;
          ptr_d   = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
          state_d = (win_opa >= NW'(2)) ? CALC : DONE;
        end
      end
      CALC: begin
        acc_d  = prod[RW-1:0];
        ovfr_d = ovfr_q | (|prod[2*RW-1:RW]);
        if (cnt_q == {1'b0, n_q}) state_d = DONE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      n_q     <= '0;
      id_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovfr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      n_q     <= n_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovfr_q  <= ovfr_d;
    end
  end

  // Outputs are registered off the next state so done/result line up with the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      did_q  <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      if (state_d == DONE) begin
        res_q <= acc_d;
        did_q <= id_d;
        ovf_q <= ovfr_d;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = did_q;
  assign result  = res_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched: latency, results, overflow, round-robin order, async reset.
module tb_fact_sched;
  import fact_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] opa;
  logic [3:0]  gnt;
  logic        busy, done, ovf;
  logic [1:0]  done_id;
  logic [31:0] result;

  int nchk  = 0;
  int npass = 0;

  fact_sched #(.NREQ(4), .NW(4), .RW(32), .IDW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .opa     (opa),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Single request from requester k with operand n; DUT must be idle on entry.
  task automatic job(input int k, input int n, input logic [31:0] eres,
                     input logic eovf, input int elat);
    int         lat;
    logic       bad;
    logic [3:0] eg;
    eg  = 4'(1 << k);
    opa = '0;
    opa[k*4 +: 4] = 4'(n);
    req = eg;
    #1;
    chk($sformatf("gnt_r%0d_n%0d", k, n), gnt, eg);
    chk($sformatf("busy_at_T_n%0d", n), busy, 0);
    step();
    req = '0;
    lat = 1;
    bad = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || gnt !== 4'b0) bad = 1'b1;
      step();
      lat++;
    end
    chk($sformatf("latency_n%0d", n), lat, elat);
    chk($sformatf("busy_gnt_calc_n%0d", n), bad, 0);
    chk($sformatf("busy_at_done_n%0d", n), busy, 1);
    chk($sformatf("result_n%0d", n), result, eres);
    chk($sformatf("done_id_n%0d", n), done_id, k);
    chk($sformatf("ovf_n%0d", n), ovf, eovf);
    step();
    chk($sformatf("idle_after_n%0d", n), {busy, done}, 0);
    chk($sformatf("result_hold_n%0d", n), result, eres);
  endtask

  initial begin
    int         g, d, ndone;
    int         gcyc [4];
    int         gid  [4];
    int         did  [4];
    logic [31:0] dres [4];
    logic [3:0] clr;

    reset = 1'b0;
    req   = '0;
    opa   = '0;
    repeat (3) step();
    chk("in_reset", {gnt, busy, done, done_id, ovf, result}, 0);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("idle_c%0d", c), {gnt, busy, done, done_id, ovf, result}, 0);
    end

    job(0, 5, 32'd120, 1'b0, 5);
    job(1, 0, 32'd1, 1'b0, 1);
    job(2, 1, 32'd1, 1'b0, 1);
    job(3, MAX_NOOVF_N, 32'd479001600, 1'b0, 12);
    job(0, 13, 32'd1932053504, 1'b1, 13);
    job(1, 3, 32'd6, 1'b0, 3);
    job(3, 2, 32'd2, 1'b0, 2);

    // Pointer is 0 here; four contenders with n=3 are served 4 cycles apart.
    req = 4'hF;
    opa = 16'h3333;
    g = 0;
    d = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      clr = gnt;
      if (gnt !== 4'b0 && g < 4) begin
        gcyc[g] = c;
        gid[g]  = -1;
        for (int b = 0; b < 4; b++) if (gnt[b]) gid[g] = b;
        g++;
      end
      if (done === 1'b1 && d < 4) begin
        did[d]  = int'(done_id);
        dres[d] = result;
        d++;
      end
      step();
      req = req & ~clr;
    end
    chk("rr_grant_count", g, 4);
    chk("rr_done_count", d, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr_order_%0d", j), gid[j], j);
      chk($sformatf("rr_cycle_%0d", j), gcyc[j], 4 * j);
      chk($sformatf("rr_done_id_%0d", j), did[j], j);
      chk($sformatf("rr_result_%0d", j), dres[j], 6);
    end
    req = '0;
    step();
    job(2, 4, 32'd24, 1'b0, 4);

    // Job in flight is killed by reset at T+4.
    opa = '0;
    opa[3:0] = 4'd9;
    req = 4'b0001;
    #1;
    chk("kill_gnt", gnt, 4'b0001);
    step();
    req = '0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("kill_busy", busy, 0);
    chk("kill_done", done, 0);
    chk("kill_result", result, 0);
    chk("kill_done_id", done_id, 0);
    chk("kill_ovf", ovf, 0);
    chk("kill_gnt_rst", gnt, 0);
    step();
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      step();
    end
    chk("kill_no_done", ndone, 0);
    job(1, 4, 32'd24, 1'b0, 4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fact_sched.md
Name: fact_sched

Overview:
Round-robin scheduler that shares one iterative factorial engine among NREQ requesters. It arbitrates, latches the winner's operand, and sequences one multiply per clock. It returns the result with the requester ID and an overflow flag. It sits in front of the factorial datapath and replaces per-client combinational factorial logic with a single time-shared multi-cycle unit.

Parameters:
NREQ, 4, number of requesters (2..8)
NW, 4, operand width; max operand 2^NW-1
RW, 32, result width; products truncated to RW bits
IDW, 2, requester ID width, equal to clog2(NREQ)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level; held until granted
opa  input  NREQ*NW  packed operands; slice k belongs to requester k
gnt  output  NREQ  one-hot, one-cycle pulse in the accept cycle
busy  output  1  high from the cycle after accept until the DONE cycle inclusive
done  output  1  one-cycle pulse, result valid
done_id  output  IDW  requester served by the current/last done
result  output  RW  factorial of the latched operand, low RW bits
ovf  output  1  true result exceeded RW bits; valid with done

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; round-robin pointer goes to 0.
  - gnt, busy, done, done_id, result, ovf, accumulator and counter all go to 0.
  - A job in flight is dropped, with no done pulse and no grant.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If req has no bits set, stay in IDLE.
  - Otherwise grant the first set bit searching from the pointer upward with wrap. Call this accept cycle T.
  - At T: gnt[k]=1; latch n=opa slice k and id=k; acc=1; i=2; ovf_r=0; pointer=(k+1) mod NREQ.
  - If n>=2, next state is CALC; otherwise next state is DONE.
- CALC:
  - Each cycle: acc=low RW bits of acc*i, computed at full 2*RW width.
  - If the upper RW bits are nonzero, ovf_r=1 (sticky).
  - If i==n, go to DONE; otherwise i=i+1.
  - The counter is NW+1 bits wide, so n=2^NW-1 never wraps.
- DONE, one cycle:
  - done=1; result=acc; done_id=id; ovf=ovf_r. All are registered outputs.
  - result, done_id and ovf hold until the next done.
  - Next state is IDLE.
- Latency: done is asserted at cycle T+max(n,1). 0! = 1 and 1! = 1.
- Next accept is possible at T+max(n,1)+1. gnt never occurs while busy=1 or done=1.
- Requests arriving in CALC/DONE wait. A req dropped before grant is ignored. opa is sampled only in the accept cycle.
- A requester that keeps req high after its grant is treated as a new request and is served again in round-robin order.
- gnt is zero in every cycle except the accept cycle. At most one gnt bit is set.

Decomposition:
- Package fact_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - default widths NW/RW;
  - the constant MAX_NOOVF_N=12 (largest n whose factorial fits in 32 bits), for the bench.
- One sub-module, rr_arbiter:
  - inputs req and pointer; outputs one-hot grant and winner index;
  - combinational, parameterised by NREQ.
- The FSM, datapath and output registers stay in fact_sched.

Test Plan:
- Reset release, no req for 10 cycles: all outputs remain 0.
- req[0]=1, opa0=5, accept at T:
  - gnt=0001 at T; busy T+1..T+5;
  - done at T+5 with result=120, done_id=0, ovf=0.
- Single requests, opa=0 and opa=1:
  - done at T+1, result=1.
  - opa=12: result=479001600, ovf=0, done at T+12.
- Single request, opa=13:
  - result=1932053504 (6227020800 mod 2^32), ovf=1.
  - A following opa=3 job returns result=6, ovf=0 (ovf clears per job).
- All four req high with opa=3, held until each gnt:
  - grants in order 0,1,2,3, each 4 cycles apart;
  - each done gives result=6 with done_id matching.
  - Then req[2] alone is granted immediately.
- opa0=9 granted; reset pulled low at T+4 for 1 cycle:
  - outputs 0 immediately; no done pulse for that job.
  - After release, req[1] opa=4 is granted first (pointer reset to 0, req[0] low); result=24.
